mem_stage: RTL

Memory-access stage of the five-stage LoongArch pipeline, sitting between the execute stage and the `wb` stage. It holds one instruction in a pipeline register, sign/zero-extends and aligns load data returned by the synchronous data SRAM, and forwards the result to decode. It also passes CSR and exception fields unchanged to `wb` over the MEM-to-WB bus, and drops its contents when `wb` raises an exception or ERTN flush.

---
 rtl/mem_stage_pkg.sv | 47 ++++
 rtl/mem_stage_if.sv | 36 +++
 rtl/mem_stage_load_align.sv | 35 +++
 rtl/mem_stage.sv | 102 ++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths, load-type codes and bus layouts for the memory-access stage.
package mem_stage_pkg;

    localparam int EXE_TO_MEM_BUS_WD = 156;
    localparam int MEM_TO_WB_BUS_WD  = 152;

    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_B  = 3'b001,
        LD_H  = 3'b010,
        LD_BU = 3'b011,
        LD_HU = 3'b100
    } ld_type_e;

    // Execute-to-memory bus, fields listed MSB to LSB.
    typedef struct packed {
        logic        csr_re;
        logic [31:0] csr_wvalue;
        logic [13:0] csr_num;
        logic        csr_we;
        logic [31:0] csr_wmask;
        logic        syscall;
        logic        ertn;
        logic [2:0]  ld_type;
        logic        load_op;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } exe_to_mem_t;

    // Memory-to-writeback bus, fields listed MSB to LSB.
    typedef struct packed {
        logic        csr_re;
        logic [31:0] csr_wvalue;
        logic [13:0] csr_num;
        logic        csr_we;
        logic [31:0] csr_wmask;
        logic        syscall;
        logic        ertn;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } mem_to_wb_t;

endpackage

// File: rtl/mem_stage_if.sv
// Signals between the memory-access stage and its neighbours (execute, SRAM, wb, decode).
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic        exe_to_mem_valid;
    exe_to_mem_t exe_to_mem_bus;
    logic        mem_allowin;
    logic [31:0] data_sram_rdata;
    logic        mem_to_wb_valid;
    mem_to_wb_t  mem_to_wb_bus;
    logic        wb_allowin;
    logic        wb_ex;
    logic        ertn_flush;
    logic        gr_we_mem;
    logic [4:0]  dest_mem;
    logic [31:0] forward_data_mem;
    logic        mem_csr_re;
    logic        mem_ex_ertn;

    // Surrounding pipeline side.
    modport master (
        output exe_to_mem_valid, exe_to_mem_bus, data_sram_rdata,
               wb_allowin, wb_ex, ertn_flush,
        input  mem_allowin, mem_to_wb_valid, mem_to_wb_bus,
               gr_we_mem, dest_mem, forward_data_mem, mem_csr_re, mem_ex_ertn
    );

    // Memory-access stage side.
    modport slave (
        input  exe_to_mem_valid, exe_to_mem_bus, data_sram_rdata,
               wb_allowin, wb_ex, ertn_flush,
        output mem_allowin, mem_to_wb_valid, mem_to_wb_bus,
               gr_we_mem, dest_mem, forward_data_mem, mem_csr_re, mem_ex_ertn
    );

endinterface

// File: rtl/mem_stage_load_align.sv
// Picks the addressed byte/half of a load word and sign- or zero-extends it.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  ld_type,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection and extension; unaligned low address bits are ignored.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves one unassigned and no latch appears.
        byte_sel = raw[7:0];
        half_sel = addr_lo[1] ? raw[31:16] : raw[15:0];
        data     = raw;
        case (addr_lo)
            2'd1:    byte_sel = raw[15:8];
            2'd2:    byte_sel = raw[23:16];
            2'd3:    byte_sel = raw[31:24];
            default: byte_sel = raw[7:0];
        endcase
        case (ld_type_e'(ld_type))
            LD_B:    data = {{24{byte_sel[7]}}, byte_sel};
            LD_H:    data = {{16{half_sel[15]}}, half_sel};
            LD_BU:   data = {24'b0, byte_sel};
            LD_HU:   data = {16'b0, half_sel};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction, aligns load data, feeds wb and decode.
module mem_stage
    import mem_stage_pkg::*;
(
    input logic       clk,
    input logic       reset,
    mem_stage_if.slave pipe
);

    logic        mem_valid;
    exe_to_mem_t bus_reg;
    logic [31:0] rbuf;
    logic        rbuf_valid;

    logic        ready_go;
    logic        allowin;
    logic        flush;
    logic        accept;
    logic        leave;
    logic        capture;
    logic [31:0] raw;
    logic [31:0] aligned;
    logic [31:0] final_result;
    mem_to_wb_t  out_bus;

    assign ready_go = 1'b1;
    assign allowin  = !mem_valid | (ready_go & pipe.wb_allowin);
    assign flush    = pipe.wb_ex | pipe.ertn_flush;
    assign accept   = pipe.exe_to_mem_valid & allowin;
    assign leave    = mem_valid & ready_go & pipe.wb_allowin;
    // The SRAM word is only held for one cycle; park it if the instruction cannot leave yet.
    assign capture  = mem_valid & !rbuf_valid & !pipe.wb_allowin;

    // Pipeline register; a flush wins over a simultaneous accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_valid <= 1'b0;
            bus_reg   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            if (flush) begin
                mem_valid <= 1'b0;
            end else if (allowin) begin
                mem_valid <= pipe.exe_to_mem_valid;
            end
            if (accept && !flush) begin
                bus_reg <= pipe.exe_to_mem_bus;
            end
        end
    end

    // Read-data buffer: filled in the first stalled cycle, dropped on leave or flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rbuf_valid <= 1'b0;
            // NOTE: the data buffer is reset too, so the wb bus is fully defined straight out of reset.
            rbuf       <= '0;
        end else if (flush || leave) begin
            rbuf_valid <= 1'b0;
        end else if (capture) begin
            rbuf_valid <= 1'b1;
            rbuf       <= pipe.data_sram_rdata;
        end
    end

    assign raw = rbuf_valid ? rbuf : pipe.data_sram_rdata;

    load_align u_load_align (
        .raw     (raw),
        .addr_lo (bus_reg.alu_result[1:0]),
        .ld_type (bus_reg.ld_type),
        .data    (aligned)
    );

    assign final_result = bus_reg.load_op ? aligned : bus_reg.alu_result;

    // Pack the wb bus; CSR and exception fields pass through untouched.
    always_comb begin
        out_bus              = '0;
        out_bus.csr_re       = bus_reg.csr_re;
        out_bus.csr_wvalue   = bus_reg.csr_wvalue;
        out_bus.csr_num      = bus_reg.csr_num;
        out_bus.csr_we       = bus_reg.csr_we;
        out_bus.csr_wmask    = bus_reg.csr_wmask;
        out_bus.syscall      = bus_reg.syscall;
        out_bus.ertn         = bus_reg.ertn;
        out_bus.gr_we        = bus_reg.gr_we;
        out_bus.dest         = bus_reg.dest;
        out_bus.final_result = final_result;
        out_bus.pc           = bus_reg.pc;
    end

    assign pipe.mem_allowin      = allowin;
    assign pipe.mem_to_wb_valid  = mem_valid & ready_go;
    assign pipe.mem_to_wb_bus    = out_bus;
    assign pipe.gr_we_mem        = mem_valid & bus_reg.gr_we;
    assign pipe.dest_mem         = mem_valid ? bus_reg.dest : 5'd0;
    assign pipe.forward_data_mem = mem_valid ? final_result : 32'd0;
    assign pipe.mem_csr_re       = mem_valid & bus_reg.csr_re;
    assign pipe.mem_ex_ertn      = mem_valid & (bus_reg.syscall | bus_reg.ertn);

endmodule
